// File: rtl/even_count_monitor_pkg.sv
// Shared constants, state and step-class types for the even counter family.
package even_count_pkg;

    localparam int unsigned VAL_W = 4;

    localparam logic [VAL_W-1:0] MIN_EVEN = 4'd0;
    localparam logic [VAL_W-1:0] MAX_EVEN = 4'd14;
    localparam logic [VAL_W-1:0] STEP     = 4'd2;

    // A -STEP move modulo 16 has the same bit pattern as MAX_EVEN.
    localparam logic [VAL_W-1:0] DELTA_DOWN = MAX_EVEN;
    localparam logic [VAL_W-1:0] DELTA_HOLD = 4'd0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } mon_state_t;

    typedef enum logic [2:0] {
        UP   = 3'd0,
        DOWN = 3'd1,
        HOLD = 3'd2,
        BAD  = 3'd3,
        ODD  = 3'd4
    } step_class_t;

    // Classify a transition prev -> cur; an odd value outranks the delta check.
    function automatic step_class_t classify_step(input logic [VAL_W-1:0] prev,
                                                  input logic [VAL_W-1:0] cur);
        logic [VAL_W-1:0] delta;
        step_class_t      cls;
        delta = cur - prev;
        if (cur[0]) begin
            cls = ODD;
        end else begin
            case (delta)
                STEP:       cls = UP;
                DELTA_DOWN: cls = DOWN;
                DELTA_HOLD: cls = HOLD;
                default:    cls = BAD;
            endcase
        end
        return cls;
    endfunction

endpackage

// File: rtl/even_count_monitor_if.sv
// Sample/status bus between an observer (master) and the count monitor (slave).
interface even_count_monitor_if
    import even_count_pkg::*;
#(
    parameter int unsigned ERR_W = 8
);
    logic             sample_valid;
    logic [VAL_W-1:0] count_in;
    logic             clear_err;

    logic             locked;
    logic             dir_up;
    logic             dir_down;
    logic             holding;
    logic             step_err;
    logic             err_sticky;
    logic [ERR_W-1:0] err_count;
    logic [VAL_W-1:0] last_value;

    modport master (
        output sample_valid, count_in, clear_err,
        input  locked, dir_up, dir_down, holding,
        input  step_err, err_sticky, err_count, last_value
    );

    modport slave (
        input  sample_valid, count_in, clear_err,
        output locked, dir_up, dir_down, holding,
        output step_err, err_sticky, err_count, last_value
    );

endinterface

// File: rtl/even_count_monitor_classify.sv
// Purely combinational step classifier: prev -> cur into UP/DOWN/HOLD/BAD/ODD.
module even_step_classify
    import even_count_pkg::*;
(
    input  logic [VAL_W-1:0] prev,
    input  logic [VAL_W-1:0] cur,
    output step_class_t      step_class
);

    // Delta and parity decision lives in the package so the counter can share it.
    assign step_class = classify_step(prev, cur);

endmodule

// File: rtl/even_count_monitor.sv
// Receive-side checker for an even up/down counter: lock, direction and error stats.
module even_count_monitor
    import even_count_pkg::*;
#(
    parameter int unsigned LOCK_STEPS = 3,
    parameter int unsigned ERR_W      = 8
) (
    input  logic               clk,
    input  logic               reset,
    even_count_monitor_if.slave bus
);

    localparam logic [ERR_W-1:0] ERR_MAX  = '1;
    localparam logic [3:0]       LOCK_CNT = 4'(LOCK_STEPS);

    mon_state_t       r_state;
    logic [3:0]       r_good_cnt;
    logic [VAL_W-1:0] r_last_value;
    logic             r_locked;
    logic             r_dir_up;
    logic             r_dir_down;
    logic             r_holding;
    logic             r_step_err;
    logic             r_err_sticky;
    logic [ERR_W-1:0] r_err_count;

    step_class_t      w_class;
    logic             w_err;
    logic [3:0]       w_good_inc;

    even_step_classify u_classify (
        .prev       (r_last_value),
        .cur        (bus.count_in),
        .step_class (w_class)
    );

    // Without a reference only parity can be judged; otherwise BAD and ODD are errors.
    assign w_err = bus.sample_valid &
                   ((r_state == IDLE) ? bus.count_in[0]
                                      : ((w_class == BAD) || (w_class == ODD)));

    assign w_good_inc = r_good_cnt + 4'd1;

    // Lock FSM, reference tracking, direction flags and error bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_good_cnt   <= 4'd0;
            r_last_value <= MIN_EVEN;
            r_locked     <= 1'b0;
            r_dir_up     <= 1'b0;
            r_dir_down   <= 1'b0;
            r_holding    <= 1'b0;
            r_step_err   <= 1'b0;
            r_err_sticky <= 1'b0;
            r_err_count  <= '0;
        end else begin
            r_step_err <= w_err;

            if (bus.clear_err) begin
                r_err_count  <= '0;
                r_err_sticky <= 1'b0;
            end else if (w_err) begin
                r_err_sticky <= 1'b1;
                if (r_err_count != ERR_MAX) begin
                    r_err_count <= r_err_count + ERR_W'(1);
                end
            end

            if (bus.sample_valid) begin
                case (r_state)
                    IDLE: begin
                        if (!bus.count_in[0]) begin
                            r_last_value <= bus.count_in;
                            r_state      <= ACQ;
                            r_good_cnt   <= 4'd0;
                            r_dir_up     <= 1'b0;
                            r_dir_down   <= 1'b0;
                            r_holding    <= 1'b0;
                        end
                    end
                    ACQ, LOCKED: begin
                        case (w_class)
                            UP, DOWN, HOLD: begin
                                r_last_value <= bus.count_in;
                                r_dir_up     <= (w_class == UP);
                                r_dir_down   <= (w_class == DOWN);
                                r_holding    <= (w_class == HOLD);
                                if (r_state == ACQ) begin
                                    r_good_cnt <= w_good_inc;
                                    if (w_good_inc == LOCK_CNT) begin
                                        r_state  <= LOCKED;
                                        r_locked <= 1'b1;
                                    end
                                end
                            end
                            BAD: begin
                                // Re-acquire from the jumped-to value (e.g. a parallel load).
                                r_last_value <= bus.count_in;
                                r_good_cnt   <= 4'd0;
                                r_dir_up     <= 1'b0;
                                r_dir_down   <= 1'b0;
                                r_holding    <= 1'b0;
                                r_state      <= ACQ;
                                r_locked     <= 1'b0;
                            end
                            default: begin
                                // Odd value: the reference is no longer trusted.
                                r_good_cnt <= 4'd0;
                                r_dir_up   <= 1'b0;
                                r_dir_down <= 1'b0;
                                r_holding  <= 1'b0;
                                r_state    <= IDLE;
                                r_locked   <= 1'b0;
                            end
                        endcase
                    end
                    default: begin
                        r_state  <= IDLE;
                        r_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.locked     = r_locked;
    assign bus.dir_up     = r_dir_up;
    assign bus.dir_down   = r_dir_down;
    assign bus.holding    = r_holding;
    assign bus.step_err   = r_step_err;
    assign bus.err_sticky = r_err_sticky;
    assign bus.err_count  = r_err_count;
    assign bus.last_value = r_last_value;

endmodule

// File: tb/tb_even_count_monitor.sv
// Scoreboard bench for even_count_monitor: one 8-bit and one 2-bit error-counter instance.
module tb_even_count_monitor;
    import even_count_pkg::*;

    localparam int N = 0;
    localparam int U = 1;
    localparam int D = 2;
    localparam int H = 3;

    typedef struct packed {
        logic       lk;
        logic       up;
        logic       dn;
        logic       hd;
        logic       se;
        logic       es;
        logic [7:0] ec;
        logic [3:0] lv;
    } exp_t;

    typedef struct {
        logic       rst;
        logic       v;
        logic [3:0] c;
        logic       clr;
        exp_t       e;
        int         ec2;
    } row_t;

    logic clk = 1'b0;
    logic reset;

    even_count_monitor_if #(.ERR_W(8)) bus8 ();
    even_count_monitor_if #(.ERR_W(2)) bus2 ();

    assign bus2.sample_valid = bus8.sample_valid;
    assign bus2.count_in     = bus8.count_in;
    assign bus2.clear_err    = bus8.clear_err;

    even_count_monitor #(.LOCK_STEPS(3), .ERR_W(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8)
    );

    even_count_monitor #(.LOCK_STEPS(3), .ERR_W(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   ec2_q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic exp_t mk(input logic lk, input int d, input logic se,
                                input logic es, input int ec, input int lv);
        exp_t e;
        e.lk = lk;
        e.up = (d == U);
        e.dn = (d == D);
        e.hd = (d == H);
        e.se = se;
        e.es = es;
        e.ec = 8'(ec);
        e.lv = 4'(lv);
        return e;
    endfunction

    function automatic row_t row(input logic rst, input logic v, input int c,
                                 input logic clr, input exp_t e, input int ec2);
        row_t r;
        r.rst = rst;
        r.v   = v;
        r.c   = 4'(c);
        r.clr = clr;
        r.e   = e;
        r.ec2 = ec2;
        return r;
    endfunction

    function automatic exp_t observe();
        exp_t o;
        o.lk = bus8.locked;
        o.up = bus8.dir_up;
        o.dn = bus8.dir_down;
        o.hd = bus8.holding;
        o.se = bus8.step_err;
        o.es = bus8.err_sticky;
        o.ec = bus8.err_count;
        o.lv = bus8.last_value;
        return o;
    endfunction

    // Drive one cycle of stimulus, queue its expected result, sample #1 after the edge.
    task automatic drive(input row_t r);
        reset             = r.rst;
        bus8.sample_valid = r.v;
        bus8.count_in     = r.c;
        bus8.clear_err    = r.clr;
        exp_q.push_back(r.e);
        ec2_q.push_back(r.ec2);
        @(posedge clk);
        #1;
        reset             = 1'b0;
        bus8.sample_valid = 1'b0;
        bus8.clear_err    = 1'b0;
    endtask

    task automatic test_reset();
        exp_t got;
        exp_t want;
        int   w2;
        drive(row(1'b1, 1'b1, 7, 1'b0, mk(0, N, 0, 0, 0, 0), 0));
        got  = observe();
        want = exp_q.pop_front();
        w2   = ec2_q.pop_front();
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL reset: got %h want %h", got, want);
        end
        total++;
        if ({bus2.locked, bus2.step_err, bus2.err_sticky, bus2.err_count} !== {3'b000, 2'(w2)}) begin
            bad++;
            $display("FAIL reset_w2: got lk=%b se=%b es=%b ec=%0d want all 0",
                     bus2.locked, bus2.step_err, bus2.err_sticky, bus2.err_count);
        end
    endtask

    task automatic test_acquire();
        row_t rows[$];
        exp_t got;
        exp_t want;
        rows.push_back(row(0, 1, 0, 0, mk(0, N, 0, 0, 0, 0), 0));
        rows.push_back(row(0, 1, 2, 0, mk(0, U, 0, 0, 0, 2), 0));
        rows.push_back(row(0, 1, 4, 0, mk(0, U, 0, 0, 0, 4), 0));
        rows.push_back(row(0, 1, 6, 0, mk(1, U, 0, 0, 0, 6), 0));
        rows.push_back(row(0, 0, 9, 0, mk(1, U, 0, 0, 0, 6), 0));
        foreach (rows[i]) begin
            drive(rows[i]);
            got  = observe();
            want = exp_q.pop_front();
            void'(ec2_q.pop_front());
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL acquire[%0d]: got lk=%b u/d/h=%b%b%b se=%b es=%b ec=%0d lv=%0d want lk=%b u/d/h=%b%b%b se=%b es=%b ec=%0d lv=%0d",
                         i, got.lk, got.up, got.dn, got.hd, got.se, got.es, got.ec, got.lv,
                         want.lk, want.up, want.dn, want.hd, want.se, want.es, want.ec, want.lv);
            end
        end
    endtask

    task automatic test_wrap_up();
        row_t rows[$];
        exp_t got;
        exp_t want;
        rows.push_back(row(0, 1, 8,  0, mk(1, U, 0, 0, 0, 8),  0));
        rows.push_back(row(0, 1, 10, 0, mk(1, U, 0, 0, 0, 10), 0));
        rows.push_back(row(0, 1, 12, 0, mk(1, U, 0, 0, 0, 12), 0));
        rows.push_back(row(0, 1, 14, 0, mk(1, U, 0, 0, 0, 14), 0));
        rows.push_back(row(0, 1, 0,  0, mk(1, U, 0, 0, 0, 0),  0));
        rows.push_back(row(0, 1, 2,  0, mk(1, U, 0, 0, 0, 2),  0));
        foreach (rows[i]) begin
            drive(rows[i]);
            got  = observe();
            want = exp_q.pop_front();
            void'(ec2_q.pop_front());
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL wrap_up[%0d]: got lk=%b u/d/h=%b%b%b se=%b ec=%0d lv=%0d want lk=%b u/d/h=%b%b%b se=%b ec=%0d lv=%0d",
                         i, got.lk, got.up, got.dn, got.hd, got.se, got.ec, got.lv,
                         want.lk, want.up, want.dn, want.hd, want.se, want.ec, want.lv);
            end
        end
    endtask

    task automatic test_down_hold();
        row_t rows[$];
        exp_t got;
        exp_t want;
        rows.push_back(row(0, 1, 4,  0, mk(1, U, 0, 0, 0, 4),  0));
        rows.push_back(row(0, 1, 2,  0, mk(1, D, 0, 0, 0, 2),  0));
        rows.push_back(row(0, 1, 0,  0, mk(1, D, 0, 0, 0, 0),  0));
        rows.push_back(row(0, 1, 14, 0, mk(1, D, 0, 0, 0, 14), 0));
        rows.push_back(row(0, 1, 14, 0, mk(1, H, 0, 0, 0, 14), 0));
        foreach (rows[i]) begin
            drive(rows[i]);
            got  = observe();
            want = exp_q.pop_front();
            void'(ec2_q.pop_front());
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL down_hold[%0d]: got lk=%b u/d/h=%b%b%b se=%b lv=%0d want lk=%b u/d/h=%b%b%b se=%b lv=%0d",
                         i, got.lk, got.up, got.dn, got.hd, got.se, got.lv,
                         want.lk, want.up, want.dn, want.hd, want.se, want.lv);
            end
        end
    endtask

    task automatic test_bad_jump();
        row_t rows[$];
        exp_t got;
        exp_t want;
        rows.push_back(row(0, 1, 0,  0, mk(1, U, 0, 0, 0, 0),  0));
        rows.push_back(row(0, 1, 2,  0, mk(1, U, 0, 0, 0, 2),  0));
        rows.push_back(row(0, 1, 4,  0, mk(1, U, 0, 0, 0, 4),  0));
        rows.push_back(row(0, 1, 6,  0, mk(1, U, 0, 0, 0, 6),  0));
        rows.push_back(row(0, 1, 10, 0, mk(0, N, 1, 1, 1, 10), 0));
        rows.push_back(row(0, 0, 0,  0, mk(0, N, 0, 1, 1, 10), 0));
        rows.push_back(row(0, 1, 12, 0, mk(0, U, 0, 1, 1, 12), 0));
        rows.push_back(row(0, 1, 14, 0, mk(0, U, 0, 1, 1, 14), 0));
        rows.push_back(row(0, 1, 0,  0, mk(1, U, 0, 1, 1, 0),  0));
        foreach (rows[i]) begin
            drive(rows[i]);
            got  = observe();
            want = exp_q.pop_front();
            void'(ec2_q.pop_front());
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL bad_jump[%0d]: got lk=%b u/d/h=%b%b%b se=%b es=%b ec=%0d lv=%0d want lk=%b u/d/h=%b%b%b se=%b es=%b ec=%0d lv=%0d",
                         i, got.lk, got.up, got.dn, got.hd, got.se, got.es, got.ec, got.lv,
                         want.lk, want.up, want.dn, want.hd, want.se, want.es, want.ec, want.lv);
            end
        end
    endtask

    task automatic test_odd();
        row_t rows[$];
        exp_t got;
        exp_t want;
        rows.push_back(row(0, 1, 2, 0, mk(1, U, 0, 1, 1, 2), 0));
        rows.push_back(row(0, 1, 4, 0, mk(1, U, 0, 1, 1, 4), 0));
        rows.push_back(row(0, 1, 6, 0, mk(1, U, 0, 1, 1, 6), 0));
        rows.push_back(row(0, 1, 8, 0, mk(1, U, 0, 1, 1, 8), 0));
        rows.push_back(row(0, 1, 7, 0, mk(0, N, 1, 1, 2, 8), 0));
        rows.push_back(row(0, 1, 4, 0, mk(0, N, 0, 1, 2, 4), 0));
        rows.push_back(row(0, 1, 3, 0, mk(0, N, 1, 1, 3, 4), 0));
        rows.push_back(row(0, 1, 9, 0, mk(0, N, 1, 1, 4, 4), 0));
        rows.push_back(row(0, 1, 6, 0, mk(0, N, 0, 1, 4, 6), 0));
        rows.push_back(row(0, 1, 6, 0, mk(0, H, 0, 1, 4, 6), 0));
        foreach (rows[i]) begin
            drive(rows[i]);
            got  = observe();
            want = exp_q.pop_front();
            void'(ec2_q.pop_front());
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL odd[%0d]: got lk=%b u/d/h=%b%b%b se=%b es=%b ec=%0d lv=%0d want lk=%b u/d/h=%b%b%b se=%b es=%b ec=%0d lv=%0d",
                         i, got.lk, got.up, got.dn, got.hd, got.se, got.es, got.ec, got.lv,
                         want.lk, want.up, want.dn, want.hd, want.se, want.es, want.ec, want.lv);
            end
        end
    endtask

    task automatic test_clear();
        row_t rows[$];
        exp_t got;
        exp_t want;
        rows.push_back(row(0, 0, 0,  1, mk(0, H, 0, 0, 0, 6),  0));
        rows.push_back(row(0, 1, 8,  0, mk(0, U, 0, 0, 0, 8),  0));
        rows.push_back(row(0, 1, 10, 0, mk(1, U, 0, 0, 0, 10), 0));
        foreach (rows[i]) begin
            drive(rows[i]);
            got  = observe();
            want = exp_q.pop_front();
            void'(ec2_q.pop_front());
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL clear[%0d]: got lk=%b se=%b es=%b ec=%0d lv=%0d want lk=%b se=%b es=%b ec=%0d lv=%0d",
                         i, got.lk, got.se, got.es, got.ec, got.lv,
                         want.lk, want.se, want.es, want.ec, want.lv);
            end
        end
    endtask

    task automatic test_saturate_and_reset();
        row_t rows[$];
        exp_t got;
        exp_t want;
        int   w2;
        rows.push_back(row(1, 1, 0,  0, mk(0, N, 0, 0, 0, 0),  0));
        rows.push_back(row(0, 1, 0,  0, mk(0, N, 0, 0, 0, 0),  0));
        rows.push_back(row(0, 1, 4,  0, mk(0, N, 1, 1, 1, 4),  1));
        rows.push_back(row(0, 1, 8,  0, mk(0, N, 1, 1, 2, 8),  2));
        rows.push_back(row(0, 1, 12, 0, mk(0, N, 1, 1, 3, 12), 3));
        rows.push_back(row(0, 1, 0,  0, mk(0, N, 1, 1, 4, 0),  3));
        rows.push_back(row(0, 1, 4,  0, mk(0, N, 1, 1, 5, 4),  3));
        rows.push_back(row(0, 1, 8,  1, mk(0, N, 1, 0, 0, 8),  0));
        rows.push_back(row(0, 1, 10, 0, mk(0, U, 0, 0, 0, 10), 0));
        rows.push_back(row(0, 1, 12, 0, mk(0, U, 0, 0, 0, 12), 0));
        rows.push_back(row(0, 1, 14, 0, mk(1, U, 0, 0, 0, 14), 0));
        rows.push_back(row(1, 1, 0,  1, mk(0, N, 0, 0, 0, 0),  0));
        foreach (rows[i]) begin
            drive(rows[i]);
            got  = observe();
            want = exp_q.pop_front();
            w2   = ec2_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL sat8[%0d]: got lk=%b u/d/h=%b%b%b se=%b es=%b ec=%0d lv=%0d want lk=%b u/d/h=%b%b%b se=%b es=%b ec=%0d lv=%0d",
                         i, got.lk, got.up, got.dn, got.hd, got.se, got.es, got.ec, got.lv,
                         want.lk, want.up, want.dn, want.hd, want.se, want.es, want.ec, want.lv);
            end
            total++;
            if ({bus2.err_count, bus2.step_err, bus2.err_sticky, bus2.locked} !== {2'(w2), want.se, want.es, want.lk}) begin
                bad++;
                $display("FAIL sat2[%0d]: got ec=%0d se=%b es=%b lk=%b want ec=%0d se=%b es=%b lk=%b",
                         i, bus2.err_count, bus2.step_err, bus2.err_sticky, bus2.locked,
                         w2, want.se, want.es, want.lk);
            end
        end
    endtask

    initial begin
        reset             = 1'b1;
        bus8.sample_valid = 1'b0;
        bus8.count_in     = 4'd0;
        bus8.clear_err    = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_acquire();
        test_wrap_up();
        test_down_hold();
        test_bad_jump();
        test_odd();
        test_clear();
        test_saturate_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
